// File: rtl/ofmap_drain_if.sv
// Handshake and map bus between the output-feature-map accumulator, the drain and its consumer.
// The master modport is the drain side. The slave modport is the environment side.
interface ofmap_drain_if #(
  parameter int DW       = 16,
  parameter int OW       = 8,
  parameter int OUT_SIZE = 25,
  parameter int IDXW     = 8
);
  logic                   start;
  logic [OUT_SIZE*DW-1:0] map_in;
  logic                   acc_clear;
  logic                   busy;
  logic                   m_valid;
  logic                   m_ready;
  logic [OW-1:0]          m_data;
  logic [IDXW-1:0]        m_row;
  logic [IDXW-1:0]        m_col;
  logic                   m_last;
  logic                   done;

  modport master (
    input  start, map_in, m_ready,
    output acc_clear, busy, m_valid, m_data, m_row, m_col, m_last, done
  );

  modport slave (
    output start, map_in, m_ready,
    input  acc_clear, busy, m_valid, m_data, m_row, m_col, m_last, done
  );
endinterface

// File: rtl/ofmap_drain.sv
// Snapshots the accumulated output map on start.
// It then streams ReLU'd, requantised, saturated words with (row,col) tags.
module ofmap_drain #(
  parameter int DW       = 16,
  parameter int OW       = 8,
  parameter int OUT_COLS = 5,
  parameter int OUT_SIZE = 25,
  parameter int IDXW     = 8,
  parameter int QSHIFT   = 4,
  parameter int RELU_EN  = 1
) (
  input  logic           clk,
  input  logic           rst,
  ofmap_drain_if.master  bus
);

  localparam int CNTW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(OUT_SIZE - 1);
  localparam logic [IDXW-1:0] LAST_COL = IDXW'(OUT_COLS - 1);
  localparam logic signed [DW-1:0] SAT_MAX = DW'((1 << (OW - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNTW-1:0]        idx_q;
  logic [IDXW-1:0]        row_q;
  logic [IDXW-1:0]        col_q;
  logic signed [DW-1:0]   buf_q [OUT_SIZE];
  logic                   m_valid_q;
  logic signed [OW-1:0]   m_data_q;
  logic                   m_last_q;
  logic                   acc_clear_q;
  logic                   busy_q;
  logic                   done_q;

  logic [CNTW-1:0]        idx_nxt_s;
  logic signed [OW-1:0]   nxt_data_s;
  logic signed [OW-1:0]   first_data_s;
  logic                   hs_s;
  logic                   capture_s;

  function automatic logic signed [OW-1:0] requant(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
    y = ((RELU_EN != 0) && x[DW-1]) ? {DW{1'b0}} : x;
    z = y >>> QSHIFT;
    if (z > SAT_MAX) begin
      return SAT_MAX[OW-1:0];
    end else if (z < SAT_MIN) begin
      return SAT_MIN[OW-1:0];
    end else begin
      return z[OW-1:0];
    end
  endfunction

  // Processed value of the word after the current one, taken from the private snapshot
  always_comb begin
    idx_nxt_s    = idx_q + CNTW'(1);
    hs_s         = m_valid_q & bus.m_ready;
    capture_s    = (state_q == S_IDLE) & bus.start;
    first_data_s = requant(bus.map_in[DW-1:0]);
    if (idx_q == LAST_IDX) begin
      nxt_data_s = {OW{1'b0}};
    end else begin
      nxt_data_s = requant(buf_q[idx_nxt_s]);
    end
  end

  // Snapshot buffer; contents only matter after a capture, so no reset
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int w = 0; w < OUT_SIZE; w++) begin
        buf_q[w] <= bus.map_in[w*DW +: DW];
      end
    end
  end

  // Drain FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= {CNTW{1'b0}};
      row_q       <= {IDXW{1'b0}};
      col_q       <= {IDXW{1'b0}};
      m_valid_q   <= 1'b0;
      m_data_q    <= {OW{1'b0}};
      m_last_q    <= 1'b0;
      acc_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q     <= S_STREAM;
            idx_q       <= {CNTW{1'b0}};
            row_q       <= {IDXW{1'b0}};
            col_q       <= {IDXW{1'b0}};
            m_valid_q   <= 1'b1;
            m_data_q    <= first_data_s;
            m_last_q    <= (LAST_IDX == {CNTW{1'b0}});
            acc_clear_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            acc_clear_q <= 1'b0;
          end
        end
        S_STREAM: begin
          acc_clear_q <= 1'b0;
          if (hs_s) begin
            if (idx_q == LAST_IDX) begin
              state_q   <= S_DONE;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              done_q    <= 1'b1;
              idx_q     <= {CNTW{1'b0}};
              row_q     <= {IDXW{1'b0}};
              col_q     <= {IDXW{1'b0}};
            end else begin
              idx_q    <= idx_nxt_s;
              m_data_q <= nxt_data_s;
              m_last_q <= (idx_nxt_s == LAST_IDX);
              if (col_q == LAST_COL) begin
                col_q <= {IDXW{1'b0}};
                row_q <= row_q + IDXW'(1);
              end else begin
                col_q <= col_q + IDXW'(1);
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          m_valid_q   <= 1'b0;
          m_last_q    <= 1'b0;
          acc_clear_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_clear = acc_clear_q;
  assign bus.busy      = busy_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_row     = row_q;
  assign bus.m_col     = col_q;
  assign bus.m_last    = m_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ofmap_drain.sv
// Directed bench for ofmap_drain: two instances, with ReLU enabled and disabled, share one stimulus.
module tb_ofmap_drain;
  localparam int DW = 16, OW = 8, OUT_COLS = 5, OUT_SIZE = 25, IDXW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic m_ready;
  logic [OUT_SIZE*DW-1:0] map_in;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int clr_cnt  = 0;
  int done_cnt = 0;
  int exp1 [OUT_SIZE];
  int exp2 [OUT_SIZE];

  always #5 clk = ~clk;

  ofmap_drain_if #(.DW(DW), .OW(OW), .OUT_SIZE(OUT_SIZE), .IDXW(IDXW)) bus1 ();
  ofmap_drain_if #(.DW(DW), .OW(OW), .OUT_SIZE(OUT_SIZE), .IDXW(IDXW)) bus2 ();

  assign bus1.start   = start;
  assign bus1.map_in  = map_in;
  assign bus1.m_ready = m_ready;
  assign bus2.start   = start;
  assign bus2.map_in  = map_in;
  assign bus2.m_ready = m_ready;

  ofmap_drain #(.DW(DW), .OW(OW), .OUT_COLS(OUT_COLS), .OUT_SIZE(OUT_SIZE), .IDXW(IDXW),
                .QSHIFT(4), .RELU_EN(1)) dut_relu (.clk(clk), .rst(rst), .bus(bus1));
  ofmap_drain #(.DW(DW), .OW(OW), .OUT_COLS(OUT_COLS), .OUT_SIZE(OUT_SIZE), .IDXW(IDXW),
                .QSHIFT(4), .RELU_EN(0)) dut_plain (.clk(clk), .rst(rst), .bus(bus2));

  // Running counts of handshakes, acc_clear cycles and done pulses
  always @(posedge clk) begin
    if (bus1.m_valid && bus1.m_ready) hs_cnt <= hs_cnt + 1;
    if (bus1.acc_clear) clr_cnt <= clr_cnt + 1;
    if (bus1.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input int w);
    check($sformatf("%s w%0d valid", tag, w), int'(bus1.m_valid), 1);
    check($sformatf("%s w%0d data", tag, w), int'($signed(bus1.m_data)), exp1[w]);
    check($sformatf("%s w%0d data_norelu", tag, w), int'($signed(bus2.m_data)), exp2[w]);
    check($sformatf("%s w%0d row", tag, w), int'(bus1.m_row), w / OUT_COLS);
    check($sformatf("%s w%0d col", tag, w), int'(bus1.m_col), w % OUT_COLS);
  endtask

  // Start a drain and walk the words; returns early once stop_w words are accepted
  task automatic drain(input string tag, input int stall_w, input int poke_w, input int stop_w);
    int hs0, clr0, dn0;
    hs0 = hs_cnt; clr0 = clr_cnt; dn0 = done_cnt;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " acc_clear"}, int'(bus1.acc_clear), 1);
    check({tag, " busy"}, int'(bus1.busy), 1);
    for (int w = 0; w < OUT_SIZE; w++) begin
      if (w == stop_w) return;
      if (w == poke_w) begin
        start = 1'b1;
        for (int i = 0; i < OUT_SIZE; i++) map_in[i*DW +: DW] = 16'h7FF0;
      end
      if (w == stall_w) begin
        m_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          check_word({tag, " stall"}, w);
          tick();
          start = 1'b0;
        end
        m_ready = 1'b1;
      end
      check_word(tag, w);
      check($sformatf("%s w%0d last", tag, w), int'(bus1.m_last), (w == OUT_SIZE - 1) ? 1 : 0);
      if (w == 1) check({tag, " acc_clear drop"}, int'(bus1.acc_clear), 0);
      tick();
      start = 1'b0;
    end
    check({tag, " done"}, int'(bus1.done), 1);
    check({tag, " valid after"}, int'(bus1.m_valid), 0);
    check({tag, " busy in done"}, int'(bus1.busy), 1);
    tick();
    check({tag, " done drop"}, int'(bus1.done), 0);
    check({tag, " idle busy"}, int'(bus1.busy), 0);
    check({tag, " handshakes"}, hs_cnt - hs0, OUT_SIZE);
    check({tag, " clear pulses"}, clr_cnt - clr0, 1);
    check({tag, " done pulses"}, done_cnt - dn0, 1);
  endtask

  task automatic load_linear();
    for (int w = 0; w < OUT_SIZE; w++) begin
      map_in[w*DW +: DW] = 16'(16 * w);
      exp1[w] = w;
      exp2[w] = w;
    end
  endtask

  initial begin
    int dn0;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; map_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset valid", int'(bus1.m_valid), 0);
    check("reset busy", int'(bus1.busy), 0);
    check("reset acc_clear", int'(bus1.acc_clear), 0);
    check("reset done", int'(bus1.done), 0);
    check("reset last", int'(bus1.m_last), 0);
    check("reset row", int'(bus1.m_row), 0);

    load_linear();
    drain("linear", -1, -1, OUT_SIZE);

    load_linear();
    map_in[0*DW +: DW] = 16'h7FF0;
    map_in[1*DW +: DW] = 16'hFF00;
    exp1[0] = 127; exp1[1] = 0;
    exp2[0] = 127; exp2[1] = -16;
    drain("sat_relu", -1, -1, OUT_SIZE);

    load_linear();
    drain("backpressure", 3, -1, OUT_SIZE);

    load_linear();
    drain("restart_ignored", -1, 7, OUT_SIZE);

    load_linear();
    drain("abort", -1, -1, 11);
    dn0 = done_cnt;
    rst = 1'b1;
    #2;
    check("abort valid", int'(bus1.m_valid), 0);
    check("abort busy", int'(bus1.busy), 0);
    check("abort acc_clear", int'(bus1.acc_clear), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("abort no done", done_cnt - dn0, 0);
    for (int w = 0; w < OUT_SIZE; w++) begin
      map_in[w*DW +: DW] = 16'(16 * (OUT_SIZE - 1 - w));
      exp1[w] = OUT_SIZE - 1 - w;
      exp2[w] = OUT_SIZE - 1 - w;
    end
    drain("after_abort", -1, -1, OUT_SIZE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
